// File: rtl/usb_rgb_cmd_pkg.sv
// rtl/usb_rgb_cmd_pkg.sv - state codes, ASCII constants and character helpers for usb_rgb_cmd
package usb_rgb_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GOT_CMD,
      ST_GOT_ARG,
      ST_GOT_Q,
      ST_DISCARD,
      ST_REPLY
   } state_t;

   typedef enum logic [1:0] {
      REP_NONE,
      REP_OK,
      REP_ER,
      REP_ST
   } rep_t;

   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;
   localparam logic [7:0] ASC_R  = 8'h52;
   localparam logic [7:0] ASC_G  = 8'h47;
   localparam logic [7:0] ASC_B  = 8'h42;
   localparam logic [7:0] ASC_Q  = 8'h3F;
   localparam logic [7:0] ASC_O  = 8'h4F;
   localparam logic [7:0] ASC_K  = 8'h4B;
   localparam logic [7:0] ASC_E  = 8'h45;

   function automatic logic [7:0] to_upper(input logic [7:0] c);
      return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
   endfunction

   function automatic logic is_term(input logic [7:0] c);
      return (c == ASC_CR) || (c == ASC_LF);
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   function automatic logic is_hex(input logic [7:0] c);
      logic [7:0] u;
      u = to_upper(c);
      return is_digit(c) || ((u >= 8'h41) && (u <= 8'h46));
   endfunction

   // 'A'..'F' have low nibble 1..6, so adding 9 lands on 10..15
   function automatic logic [3:0] hex_to_nib(input logic [7:0] c);
      logic [7:0] u;
      u = to_upper(c);
      return is_digit(c) ? c[3:0] : u[3:0] + 4'd9;
   endfunction

   function automatic logic [7:0] nib_to_asc(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
   endfunction

endpackage

// File: rtl/rgb_pwm.sv
// rtl/rgb_pwm.sv - shared prescaler and 4-bit phase driving three active-low PWM pins
module rgb_pwm #(
   parameter int PWM_DIV = 256
) (
   input  logic       clk48,
   input  logic       rst_n,
   input  logic [3:0] lvl_r,
   input  logic [3:0] lvl_g,
   input  logic [3:0] lvl_b,
   output logic       led_r_n,
   output logic       led_g_n,
   output logic       led_b_n
);

   localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PWM_DIV - 1);

   logic [PW-1:0] pre;
   logic [3:0]    phase;

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         pre   <= '0;
         phase <= 4'd0;
      end else if (pre == PRE_MAX) begin
         pre   <= '0;
         phase <= phase + 4'd1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // Combinational compare so a new level shows up the cycle after it is written
   assign led_r_n = !(phase < lvl_r);
   assign led_g_n = !(phase < lvl_g);
   assign led_b_n = !(phase < lvl_b);

endmodule

// File: rtl/usb_rgb_cmd.sv
// rtl/usb_rgb_cmd.sv - ASCII command parser setting RGB LED levels, with text replies
module usb_rgb_cmd
   import usb_rgb_cmd_pkg::*;
#(
   parameter int PWM_DIV = 256
) (
   input  logic       clk48,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       led_r_n,
   output logic       led_g_n,
   output logic       led_b_n
);

   state_t     state, state_n;
   rep_t       rep_kind;
   logic [1:0] chan;
   logic [3:0] digit;
   logic [3:0] lvl_r, lvl_g, lvl_b;
   logic [7:0] rbuf [5];
   logic [2:0] ridx, rlast;
   logic       latch_cmd, latch_dig, commit;
   logic [7:0] up;
   logic       rx_fire, tx_fire, term;

   assign rx_ready = (state != ST_REPLY);
   assign tx_valid = (state == ST_REPLY);
   assign tx_data  = tx_valid ? rbuf[ridx] : 8'h00;
   assign rx_fire  = rx_valid && rx_ready;
   assign tx_fire  = tx_valid && tx_ready;
   assign up       = to_upper(rx_data);
   assign term     = is_term(rx_data);

   always_comb begin
      state_n   = state;
      rep_kind  = REP_NONE;
      latch_cmd = 1'b0;
      latch_dig = 1'b0;
      commit    = 1'b0;
      case (state)
         ST_IDLE: if (rx_fire && !term) begin
            if (up == ASC_R || up == ASC_G || up == ASC_B) begin
               state_n   = ST_GOT_CMD;
               latch_cmd = 1'b1;
            end else if (rx_data == ASC_Q) begin
               state_n = ST_GOT_Q;
            end else begin
               state_n = ST_DISCARD;
            end
         end
         ST_GOT_CMD: if (rx_fire) begin
            if (term) begin
               state_n  = ST_REPLY;
               rep_kind = REP_ER;
            end else if (is_hex(rx_data)) begin
               state_n   = ST_GOT_ARG;
               latch_dig = 1'b1;
            end else begin
               state_n = ST_DISCARD;
            end
         end
         ST_GOT_ARG: if (rx_fire) begin
            if (term) begin
               state_n  = ST_REPLY;
               rep_kind = REP_OK;
               commit   = 1'b1;
            end else begin
               state_n = ST_DISCARD;
            end
         end
         ST_GOT_Q: if (rx_fire) begin
            if (term) begin
               state_n  = ST_REPLY;
               rep_kind = REP_ST;
            end else begin
               state_n = ST_DISCARD;
            end
         end
         ST_DISCARD: if (rx_fire && term) begin
            state_n  = ST_REPLY;
            rep_kind = REP_ER;
         end
         ST_REPLY: if (tx_fire && ridx == rlast) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         chan  <= 2'd0;
         digit <= 4'd0;
         lvl_r <= 4'd0;
         lvl_g <= 4'd0;
         lvl_b <= 4'd0;
         rbuf  <= '{default: 8'h00};
         ridx  <= 3'd0;
         rlast <= 3'd0;
      end else begin
         state <= state_n;
         if (latch_cmd) chan <= (up == ASC_R) ? 2'd0 : (up == ASC_G) ? 2'd1 : 2'd2;
         if (latch_dig) digit <= hex_to_nib(rx_data);
         if (commit) begin
            case (chan)
               2'd0:    lvl_r <= digit;
               2'd1:    lvl_g <= digit;
               default: lvl_b <= digit;
            endcase
         end
         if (tx_fire) ridx <= ridx + 3'd1;
         // Status samples the levels as they stand when the TERM is accepted
         case (rep_kind)
            REP_OK: begin
               rbuf  <= '{ASC_O, ASC_K, ASC_CR, ASC_LF, 8'h00};
               rlast <= 3'd3;
               ridx  <= 3'd0;
            end
            REP_ER: begin
               rbuf  <= '{ASC_E, ASC_R, ASC_CR, ASC_LF, 8'h00};
               rlast <= 3'd3;
               ridx  <= 3'd0;
            end
            REP_ST: begin
               rbuf  <= '{nib_to_asc(lvl_r), nib_to_asc(lvl_g), nib_to_asc(lvl_b), ASC_CR, ASC_LF};
               rlast <= 3'd4;
               ridx  <= 3'd0;
            end
            default: ;
         endcase
      end
   end

   rgb_pwm #(.PWM_DIV(PWM_DIV)) u_pwm (
      .clk48   (clk48),
      .rst_n   (rst_n),
      .lvl_r   (lvl_r),
      .lvl_g   (lvl_g),
      .lvl_b   (lvl_b),
      .led_r_n (led_r_n),
      .led_g_n (led_g_n),
      .led_b_n (led_b_n)
   );

endmodule

// File: tb/tb_usb_rgb_cmd.sv
// tb/tb_usb_rgb_cmd.sv - bench for usb_rgb_cmd against a line-level reply model
module tb_usb_rgb_cmd;

   localparam int PWM_DIV = 4;

   logic       clk48 = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic       led_r_n, led_g_n, led_b_n;

   int checks = 0;
   int errors = 0;
   int lvl [3];
   byte unsigned exp_q [$];
   byte unsigned line [$];

   usb_rgb_cmd #(.PWM_DIV(PWM_DIV)) dut (
      .clk48    (clk48),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .led_r_n  (led_r_n),
      .led_g_n  (led_g_n),
      .led_b_n  (led_b_n)
   );

   always #5 clk48 = ~clk48;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic byte unsigned upc(input byte unsigned c);
      return (c >= "a" && c <= "z") ? byte'(c - 8'd32) : c;
   endfunction

   function automatic bit ishex(input byte unsigned c);
      return (c >= "0" && c <= "9") || (upc(c) >= "A" && upc(c) <= "F");
   endfunction

   function automatic int hexval(input byte unsigned c);
      return (c <= "9") ? int'(c) - 48 : int'(upc(c)) - 55;
   endfunction

   function automatic byte unsigned nibasc(input int n);
      return (n < 10) ? byte'(48 + n) : byte'(55 + n);
   endfunction

   task automatic set_line(input string s);
      line.delete();
      for (int i = 0; i < s.len(); i++) line.push_back(s[i]);
   endtask

   // Whole-line reply rules; updates the level model as a side effect
   task automatic model_line();
      byte unsigned u0;
      exp_q.delete();
      if (line.size() == 0) return;
      u0 = upc(line[0]);
      if (line.size() == 2 && (u0 == "R" || u0 == "G" || u0 == "B") && ishex(line[1])) begin
         lvl[(u0 == "R") ? 0 : (u0 == "G") ? 1 : 2] = hexval(line[1]);
         exp_q = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
      end else if (line.size() == 1 && line[0] == 8'h3F) begin
         exp_q = '{nibasc(lvl[0]), nibasc(lvl[1]), nibasc(lvl[2]), 8'h0D, 8'h0A};
      end else begin
         exp_q = '{8'h45, 8'h52, 8'h0D, 8'h0A};
      end
   endtask

   task automatic send_byte(input byte unsigned b);
      int n;
      @(negedge clk48);
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 200) begin
         @(negedge clk48);
         n++;
      end
      if (!rx_ready) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
      @(posedge clk48);
      #1 rx_valid = 1'b0;
   endtask

   task automatic quiet(input string tag);
      repeat (3) begin
         @(negedge clk48);
         chk(tag, 32'(tx_valid), 32'd0);
      end
   endtask

   // Drains exp_q; tx_valid must be up from the first cycle after TERM until the last byte
   task automatic collect(input int stall_at);
      for (int i = 0; i < exp_q.size(); i++) begin
         bit got;
         got = 1'b0;
         while (!got) begin
            @(negedge clk48);
            chk("tx_valid_hold", 32'(tx_valid), 32'd1);
            if (tx_valid !== 1'b1) begin
               tx_ready = 1'b0;
               return;
            end
            if (i == stall_at) begin
               tx_ready = 1'b0;
               stall_at = -1;
               repeat (20) begin
                  @(negedge clk48);
                  chk("stall_valid", 32'(tx_valid), 32'd1);
                  chk("stall_data", 32'(tx_data), 32'(exp_q[i]));
                  chk("stall_rx_ready", 32'(rx_ready), 32'd0);
               end
            end
            tx_ready = ($urandom_range(0, 2) != 0);
            if (tx_ready) begin
               chk("tx_byte", 32'(tx_data), 32'(exp_q[i]));
               got = 1'b1;
            end
         end
      end
      @(negedge clk48);
      tx_ready = 1'b0;
      chk("end_tx_valid", 32'(tx_valid), 32'd0);
      chk("end_rx_ready", 32'(rx_ready), 32'd1);
   endtask

   // term_kind: 0 = CR, 1 = LF, 2 = CRLF
   task automatic run_line(input int term_kind, input int stall_at);
      foreach (line[i]) send_byte(line[i]);
      model_line();
      send_byte((term_kind == 1) ? 8'h0A : 8'h0D);
      if (exp_q.size() == 0) quiet("no_reply");
      else collect(stall_at);
      if (term_kind == 2) begin
         send_byte(8'h0A);
         quiet("crlf_lf_quiet");
      end
   endtask

   task automatic check_pwm();
      int lows [3];
      lows = '{0, 0, 0};
      repeat (16 * PWM_DIV) begin
         @(negedge clk48);
         if (!led_r_n) lows[0]++;
         if (!led_g_n) lows[1]++;
         if (!led_b_n) lows[2]++;
      end
      chk("pwm_r", 32'(lows[0]), 32'(lvl[0] * PWM_DIV));
      chk("pwm_g", 32'(lows[1]), 32'(lvl[1] * PWM_DIV));
      chk("pwm_b", 32'(lows[2]), 32'(lvl[2] * PWM_DIV));
   endtask

   initial begin
      string letters, digits;
      lvl = '{0, 0, 0};
      letters = "RGBrgb";
      digits  = "0123456789abcdefABCDEF";

      repeat (3) @(negedge clk48);
      chk("rst_rx_ready", 32'(rx_ready), 32'd1);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_leds", 32'({led_r_n, led_g_n, led_b_n}), 32'b111);
      rst_n = 1'b1;

      set_line("RA");     run_line(0, -1);
      check_pwm();
      set_line("R0");     run_line(0, -1);
      set_line("g7");     run_line(1, -1);
      set_line("?");      run_line(0, -1);
      set_line("RZ");     run_line(0, -1);
      set_line("Q12345"); run_line(0, -1);
      set_line("R");      run_line(0, -1);
      set_line("?");      run_line(0, -1);
      set_line("B5");     run_line(2, -1);
      set_line("");       run_line(1, -1);
      set_line("?");      run_line(0, 1);
      check_pwm();

      for (int k = 0; k < 40; k++) begin
         int kind;
         kind = $urandom_range(0, 4);
         line.delete();
         case (kind)
            0: begin
               line.push_back(letters[$urandom_range(0, 5)]);
               line.push_back(digits[$urandom_range(0, 21)]);
            end
            1: line.push_back(8'h3F);
            2: repeat ($urandom_range(1, 6)) line.push_back(8'($urandom_range(32, 126)));
            3: line.push_back(letters[$urandom_range(0, 5)]);
            default: ;
         endcase
         run_line($urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? 2 : -1);
         if (k % 10 == 9) check_pwm();
      end

      set_line("?");
      foreach (line[i]) send_byte(line[i]);
      model_line();
      send_byte(8'h0D);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk48);
         tx_ready = 1'b1;
         chk("pre_rst_byte", 32'(tx_data), 32'(exp_q[i]));
      end
      @(negedge clk48);
      tx_ready = 1'b0;
      chk("pre_rst_valid", 32'(tx_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
      chk("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
      chk("mid_rst_leds", 32'({led_r_n, led_g_n, led_b_n}), 32'b111);
      lvl = '{0, 0, 0};
      repeat (2) @(negedge clk48);
      rst_n = 1'b1;
      set_line("?");      run_line(0, -1);
      check_pwm();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      errors++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
